// File: rtl/tlc_pkg.sv
// tlc_pkg: shared constants and encodings for the traffic light lamp monitor
package tlc_pkg;
  localparam logic [2:0] FLT_NONE = 3'd0, FLT_CONFLICT = 3'd1, FLT_LAMP = 3'd2, FLT_PAIR = 3'd3,
                         FLT_SEQ = 3'd4, FLT_SHORT_Y = 3'd5, FLT_SHORT_G = 3'd6;
  localparam int RA = 11, YA = 10, GA = 9, RB = 8, YB = 7, GB = 6;
  localparam int RC = 5, YC = 4, GC = 3, RD = 2, YD = 1, GD = 0;
  localparam logic [11:0] ALL_RED = 12'b100_100_100_100;
  typedef enum logic [1:0] {COL_R, COL_Y, COL_G, COL_INV} col_t;
  typedef enum logic {ST_RUN, ST_FAULT} state_t;
  function automatic col_t decode(input logic [2:0] ryg);
    return ryg == 3'b100 ? COL_R : ryg == 3'b010 ? COL_Y : ryg == 3'b001 ? COL_G : COL_INV;
  endfunction
endpackage

// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer: per-pair colour history, duration counter and sequence/interval checks
module tlc_phase_timer
  import tlc_pkg::*;
#(
  parameter int YT_MIN = 2,
  parameter int GT_MIN = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  col_t col,
  output logic seq_err,
  output logic short_y,
  output logic short_g
);
  localparam int CMAX = GT_MIN > YT_MIN ? GT_MIN : YT_MIN;
  localparam int CW = $clog2(CMAX + 1);
  col_t prev;
  logic [CW-1:0] cnt;
  logic armed, chg;
  always_comb begin
    chg = col != prev;
    seq_err = en && ((prev == COL_G && col == COL_R) || (prev == COL_Y && col == COL_G) ||
                     (prev == COL_R && col == COL_Y));
    short_y = en && armed && chg && prev == COL_Y && cnt < CW'(YT_MIN);
    short_g = en && armed && chg && prev == COL_G && cnt < CW'(GT_MIN);
  end
  // the first change after reset/clear only arms: the preceding interval was not fully observed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= COL_R;
      cnt <= CW'(1);
      armed <= 1'b0;
    end else begin
      prev <= col;
      cnt <= (load || chg) ? CW'(1) : cnt == CW'(CMAX) ? cnt : cnt + CW'(1);
      armed <= !load && (armed || (en && chg));
    end
endmodule

// File: rtl/tlc_conflict_monitor.sv
// tlc_conflict_monitor: lamp-side safety monitor with latched fault and flashing all-red override
module tlc_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int YT_MIN = 2,
  parameter int GT_MIN = 5,
  parameter int FLASH_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lamps_in,
  input  logic        clr,
  output logic [11:0] lamps_out,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        flash_en
);
  localparam int DW = FLASH_DIV > 1 ? $clog2(FLASH_DIV) : 1;
  state_t state;
  col_t ca, cb, cc, cd;
  logic nr_hw, nr_sv, conflict, lamp_err, pair_err, static_ok, prev_ok, dyn_en, load, phase;
  logic seq_h, sy_h, sg_h, seq_s, sy_s, sg_s;
  logic [2:0] code_n;
  logic [DW-1:0] div;
  always_comb begin
    ca = decode(lamps_in[RA:GA]);
    cb = decode(lamps_in[RB:GB]);
    cc = decode(lamps_in[RC:GC]);
    cd = decode(lamps_in[RD:GD]);
    nr_hw = |{lamps_in[YA], lamps_in[GA], lamps_in[YC], lamps_in[GC]};
    nr_sv = |{lamps_in[YB], lamps_in[GB], lamps_in[YD], lamps_in[GD]};
    conflict = nr_hw && nr_sv;
    lamp_err = ca == COL_INV || cb == COL_INV || cc == COL_INV || cd == COL_INV;
    pair_err = lamps_in[RA:GA] != lamps_in[RC:GC] || lamps_in[RB:GB] != lamps_in[RD:GD];
    static_ok = !(conflict || lamp_err || pair_err);
    dyn_en = static_ok && prev_ok;
    load = state == ST_FAULT && clr && static_ok;
    code_n = conflict ? FLT_CONFLICT : lamp_err ? FLT_LAMP : pair_err ? FLT_PAIR :
             (seq_h || seq_s) ? FLT_SEQ : (sy_h || sy_s) ? FLT_SHORT_Y :
             (sg_h || sg_s) ? FLT_SHORT_G : FLT_NONE;
    lamps_out = rst ? ALL_RED : fault ? (phase ? ALL_RED : 12'h000) : lamps_in;
  end
  tlc_phase_timer #(.YT_MIN(YT_MIN), .GT_MIN(GT_MIN)) u_hw (
    .clk(clk), .rst(rst), .en(dyn_en), .load(load), .col(ca),
    .seq_err(seq_h), .short_y(sy_h), .short_g(sg_h)
  );
  tlc_phase_timer #(.YT_MIN(YT_MIN), .GT_MIN(GT_MIN)) u_sv (
    .clk(clk), .rst(rst), .en(dyn_en), .load(load), .col(cb),
    .seq_err(seq_s), .short_y(sy_s), .short_g(sg_s)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_RUN;
      fault <= 1'b0;
      fault_code <= FLT_NONE;
      flash_en <= 1'b0;
      phase <= 1'b1;
      div <= '0;
      prev_ok <= 1'b0;
    end else begin
      prev_ok <= static_ok;
      if (state == ST_RUN) begin
        if (code_n != FLT_NONE) begin
          state <= ST_FAULT;
          fault <= 1'b1;
          fault_code <= code_n;
          flash_en <= 1'b1;
          phase <= 1'b1;
          div <= '0;
        end
      end else if (load) begin
        state <= ST_RUN;
        fault <= 1'b0;
        fault_code <= FLT_NONE;
        flash_en <= 1'b0;
      end else begin
        div <= div == DW'(FLASH_DIV - 1) ? '0 : div + DW'(1);
        phase <= div == DW'(FLASH_DIV - 1) ? !phase : phase;
      end
    end
endmodule
